// File: rtl/hex_scroll_controller.sv
// Scrolling six-digit window over a circular buffer of hex/blank codes.
// Drives the DE10-Lite HEX5..HEX0 pins with registered active-low segments.
module hex_scroll_controller #(
  parameter int TICK_DIV = 12_500_000,
  parameter int DEPTH    = 16
) (
  input  logic       MAX10_CLK1_50,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [4:0] wr_char,
  input  logic       wr_last,
  input  logic       pause,
  input  logic       clear,
  output logic       busy,
  output logic       wrap,
  output logic [7:0] HEX0,
  output logic [7:0] HEX1,
  output logic [7:0] HEX2,
  output logic [7:0] HEX3,
  output logic [7:0] HEX4,
  output logic [7:0] HEX5
);

  localparam int AW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TICK_DIV);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

  typedef enum logic {
    S_IDLE,
    S_SHOW
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_len;
  logic [AW-1:0] r_pos;
  logic [TW-1:0] r_tick;
  logic          r_wrap;
  logic [4:0]    r_buf [DEPTH];
  logic [7:0]    r_hex [6];

  logic          w_wr_fire;
  logic          w_msg_end;
  logic          w_tick;
  logic          w_pos_last;
  logic [AW-1:0] w_walk;
  logic [AW-2:0] w_rd [6];

  // Active-low {dp,g..a}; bit 4 of the code selects a dark digit.
  function automatic logic [7:0] seg7(input logic [4:0] c);
    logic [7:0] s;
    unique case (c[3:0])
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      4'hF: s = 8'h8E;
    endcase
    return c[4] ? 8'hFF : s;
  endfunction

  assign wr_ready   = (r_state == S_IDLE);
  assign busy       = (r_state == S_SHOW);
  assign wrap       = r_wrap;

  // A clear in the same cycle wins over a pending write.
  assign w_wr_fire  = wr_valid & wr_ready & ~clear;
  assign w_msg_end  = wr_last | (r_wr_ptr == LAST_IDX);
  assign w_tick     = ~pause & (r_tick == TICK_MAX);
  assign w_pos_last = ((r_pos + AW'(1)) == r_len);

  // Walk the six window slots from pos, wrapping at len (handles len < 6).
  always_comb begin
    w_walk = r_pos;
    for (int k = 0; k < 6; k++) begin
      w_rd[k] = w_walk[AW-2:0];
      if ((w_walk + AW'(1)) == r_len)
        w_walk = '0;
      else
        w_walk = w_walk + AW'(1);
    end
  end

  // Message storage; contents are irrelevant until a message is loaded.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (w_wr_fire)
      r_buf[r_wr_ptr[AW-2:0]] <= wr_char;
  end

  // Load / show state machine with scroll tick and wrap pulse.
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_len    <= '0;
      r_pos    <= '0;
      r_tick   <= '0;
      r_wrap   <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (clear) begin
        r_state  <= S_IDLE;
        r_wr_ptr <= '0;
        r_len    <= '0;
        r_pos    <= '0;
        r_tick   <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (w_wr_fire) begin
              r_wr_ptr <= r_wr_ptr + AW'(1);
              if (w_msg_end) begin
                r_len   <= r_wr_ptr + AW'(1);
                r_pos   <= '0;
                r_tick  <= '0;
                r_state <= S_SHOW;
              end
            end
          end
          S_SHOW: begin
            if (w_tick) begin
              r_tick <= '0;
              if (w_pos_last) begin
                r_pos  <= '0;
                r_wrap <= 1'b1;
              end else begin
                r_pos <= r_pos + AW'(1);
              end
            end else if (!pause) begin
              r_tick <= r_tick + TW'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Registered segment decode of the current window; dark outside SHOW.
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 6; k++)
        r_hex[k] <= 8'hFF;
    end else if (clear || r_state != S_SHOW) begin
      for (int k = 0; k < 6; k++)
        r_hex[k] <= 8'hFF;
    end else begin
      for (int k = 0; k < 6; k++)
        r_hex[5-k] <= seg7(r_buf[w_rd[k]]);
    end
  end

  assign HEX0 = r_hex[0];
  assign HEX1 = r_hex[1];
  assign HEX2 = r_hex[2];
  assign HEX3 = r_hex[3];
  assign HEX4 = r_hex[4];
  assign HEX5 = r_hex[5];

endmodule

// File: tb/tb_hex_scroll_controller.sv
// Bench for hex_scroll_controller: message-level reference model,
// directed scenarios plus randomized load/pause/clear traffic.
module tb_hex_scroll_controller;

  localparam int TD = 4;
  localparam int DP = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_char;
  logic       wr_last;
  logic       pause;
  logic       clear;
  logic       busy;
  logic       wrap;
  logic [7:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0,
                           8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83,
                           8'hC6, 8'hA1, 8'h86, 8'h8E};

  // reference model: message queue, window start, cycles since last step
  bit         m_show;
  logic [4:0] m_msg [$];
  int         m_len;
  int         m_pos;
  int         m_cnt;
  bit         m_wrap;
  logic [7:0] m_hex [6];

  hex_scroll_controller #(.TICK_DIV(TD), .DEPTH(DP)) dut (
    .MAX10_CLK1_50(clk),
    .reset(reset),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_char(wr_char),
    .wr_last(wr_last),
    .pause(pause),
    .clear(clear),
    .busy(busy),
    .wrap(wrap),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
    .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  always #10 clk = ~clk;

  function automatic logic [7:0] dec(input logic [4:0] c);
    return c[4] ? 8'hFF : SEG[c[3:0]];
  endfunction

  function automatic logic [50:0] exp_vec();
    return {~m_show, m_show, m_wrap, m_hex[5], m_hex[4],
            m_hex[3], m_hex[2], m_hex[1], m_hex[0]};
  endfunction

  function automatic logic [50:0] obs_vec();
    return {wr_ready, busy, wrap, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  endfunction

  task automatic model_reset();
    m_show = 0;
    m_msg.delete();
    m_len  = 0;
    m_pos  = 0;
    m_cnt  = 0;
    m_wrap = 0;
    for (int j = 0; j < 6; j++) m_hex[j] = 8'hFF;
  endtask

  // One clock edge of the spec's behaviour, from inputs seen at the edge.
  task automatic model_edge();
    logic [7:0] nh [6];
    for (int j = 0; j < 6; j++) nh[j] = 8'hFF;
    if (!clear && m_show)
      for (int k = 0; k < 6; k++)
        nh[5-k] = dec(m_msg[(m_pos + k) % m_len]);
    m_hex  = nh;
    m_wrap = 0;
    if (clear) begin
      m_show = 0;
      m_msg.delete();
      m_len = 0;
      m_pos = 0;
      m_cnt = 0;
    end else if (!m_show) begin
      if (wr_valid) begin
        m_msg.push_back(wr_char);
        if (wr_last || m_msg.size() == DP) begin
          m_show = 1;
          m_len  = m_msg.size();
          m_pos  = 0;
          m_cnt  = 0;
        end
      end
    end else if (!pause) begin
      if (m_cnt == TD - 1) begin
        m_cnt  = 0;
        m_pos  = (m_pos + 1) % m_len;
        m_wrap = (m_pos == 0);
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    @(negedge clk);
  endtask

  task automatic quiet();
    wr_valid = 0;
    wr_last  = 0;
    wr_char  = '0;
    pause    = 0;
    clear    = 0;
  endtask

  task automatic test_reset();
    logic [50:0] o;
    reset = 1;
    quiet();
    model_reset();
    step();
    o = obs_vec();
    n_vec++;
    if (o !== exp_vec()) begin
      $display("FAIL reset_state: got %h want %h", o, exp_vec());
      n_err++;
    end
    reset = 0;
    step();
  endtask

  task automatic test_scroll();
    logic [50:0] o;
    int wraps;
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1;
      wr_char  = 5'(i);
      wr_last  = (i == 7);
      step();
      o = obs_vec();
      n_vec++;
      if (o !== exp_vec()) begin
        $display("FAIL scroll_load: got %h want %h", o, exp_vec());
        n_err++;
      end
    end
    quiet();
    step();
    step();
    n_vec++;
    if ({wr_ready, busy, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}
        !== {2'b01, 48'hC0F9A4B09992}) begin
      $display("FAIL scroll_first_frame: got %h %h %h%h%h%h%h%h",
               wr_ready, busy, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0);
      n_err++;
    end
    wraps = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      wraps += int'(wrap);
      o = obs_vec();
      n_vec++;
      if (o !== exp_vec()) begin
        $display("FAIL scroll_run c%0d: got %h want %h", c, o, exp_vec());
        n_err++;
      end
    end
    n_vec++;
    if (wraps != 1) begin
      $display("FAIL scroll_wrap_count: got %0d want 1", wraps);
      n_err++;
    end
  endtask

  task automatic test_short();
    logic [50:0] o;
    clear = 1;
    step();
    clear = 0;
    wr_valid = 1;
    wr_char  = 5'h0A;
    step();
    wr_char  = 5'h0B;
    wr_last  = 1;
    step();
    quiet();
    step();
    step();
    n_vec++;
    if ({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== 48'h888388838883) begin
      $display("FAIL short_frame: got %h%h%h%h%h%h want 888388838883",
               HEX5, HEX4, HEX3, HEX2, HEX1, HEX0);
      n_err++;
    end
    for (int c = 0; c < 8; c++) begin
      step();
      o = obs_vec();
      n_vec++;
      if (o !== exp_vec()) begin
        $display("FAIL short_run c%0d: got %h want %h", c, o, exp_vec());
        n_err++;
      end
    end
  endtask

  task automatic test_full();
    logic [50:0] o;
    logic [4:0]  first;
    clear = 1;
    step();
    clear = 0;
    first = 5'($urandom_range(0, 15));
    for (int i = 0; i < DP + 1; i++) begin
      wr_valid = 1;
      wr_last  = 0;
      wr_char  = (i == 0) ? first : 5'($urandom_range(0, 31));
      step();
      o = obs_vec();
      n_vec++;
      if (o !== exp_vec()) begin
        $display("FAIL full_load i%0d: got %h want %h", i, o, exp_vec());
        n_err++;
      end
    end
    quiet();
    step();
    n_vec++;
    if (HEX5 !== dec(first) || wr_ready !== 1'b0) begin
      $display("FAIL full_hex5: got %h rdy %b want %h rdy 0",
               HEX5, wr_ready, dec(first));
      n_err++;
    end
  endtask

  task automatic test_pause_clear();
    logic [50:0] o;
    logic [47:0] snap;
    int guard;
    pause = 1;
    step();
    snap = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    for (int c = 0; c < 12; c++) begin
      step();
      o = obs_vec();
      n_vec++;
      if (o !== exp_vec() || o[47:0] !== snap) begin
        $display("FAIL pause_hold c%0d: got %h want %h", c, o, exp_vec());
        n_err++;
      end
    end
    pause = 0;
    guard = 0;
    while (m_cnt != TD - 1 && guard < 10) begin
      step();
      guard++;
    end
    clear = 1;
    step();
    clear = 0;
    o = obs_vec();
    n_vec++;
    if (o !== exp_vec() || wr_ready !== 1'b1 || HEX0 !== 8'hFF) begin
      $display("FAIL clear_on_tick: got %h want %h", o, exp_vec());
      n_err++;
    end
  endtask

  task automatic test_reset_mid();
    logic [50:0] o;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1;
      wr_char  = 5'($urandom_range(0, 31));
      wr_last  = (i == 4);
      step();
    end
    quiet();
    for (int c = 0; c < 6; c++) step();
    #3 reset = 1;
    model_reset();
    #1;
    o = obs_vec();
    n_vec++;
    if (o !== exp_vec()) begin
      $display("FAIL reset_mid_async: got %h want %h", o, exp_vec());
      n_err++;
    end
    step();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1;
      wr_char  = 5'($urandom_range(0, 15));
      wr_last  = (i == 2);
      step();
    end
    quiet();
    for (int c = 0; c < 12; c++) begin
      step();
      o = obs_vec();
      n_vec++;
      if (o !== exp_vec()) begin
        $display("FAIL reset_reload c%0d: got %h want %h", c, o, exp_vec());
        n_err++;
      end
    end
  endtask

  task automatic test_random();
    logic [50:0] o;
    int target;
    int guard;
    for (int r = 0; r < 8; r++) begin
      quiet();
      clear = 1;
      step();
      target = $urandom_range(1, 20);
      guard  = 0;
      while (!m_show && guard < 60) begin
        wr_valid = ($urandom_range(0, 3) != 0);
        wr_char  = 5'($urandom_range(0, 31));
        wr_last  = (m_msg.size() == target - 1);
        pause    = ($urandom_range(0, 3) == 0);
        clear    = ($urandom_range(0, 15) == 0);
        step();
        o = obs_vec();
        n_vec++;
        if (o !== exp_vec()) begin
          $display("FAIL rand_load r%0d: got %h want %h", r, o, exp_vec());
          n_err++;
        end
        guard++;
      end
      quiet();
      for (int c = 0; c < 50; c++) begin
        wr_valid = $urandom_range(0, 1);
        wr_char  = 5'($urandom_range(0, 31));
        pause    = ($urandom_range(0, 3) == 0);
        clear    = ($urandom_range(0, 39) == 0);
        step();
        o = obs_vec();
        n_vec++;
        if (o !== exp_vec()) begin
          $display("FAIL rand_show r%0d c%0d: got %h want %h",
                   r, c, o, exp_vec());
          n_err++;
        end
      end
    end
    quiet();
  endtask

  initial begin
    test_reset();
    test_scroll();
    test_short();
    test_full();
    test_pause_clear();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
